// File: rtl/rob_commit.sv
// rob_commit: 16-entry reorder buffer.
//
// Allocates ROB ids to decoded instructions, collects results from the ALU
// (reservation station) and load/store buffer result buses, answers operand
// readiness queries, and retires entries strictly in program order.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (low freezes all state)
//   dc_*          : issue interface from the decoder
//   rob_tail      : id the next issue receives
//   rob_full      : registered, decoder must stall while high
//   rs_*, is_lsb, lsb_* : write-back buses
//   q1_*, q2_*    : combinational operand lookups (storage or same-cycle bypass)
//   commit_*      : register-file write pulse (reg write / jalr)
//   store_commit, store_id : store at head may perform
//   rob_clear, clear_pc    : flush pulse and redirect target on mispredict
module rob_commit #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_W    = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              dc_valid,
    input  logic [1:0]        dc_type,
    input  logic [4:0]        dc_rd,
    input  logic              dc_pred,
    input  logic [31:0]       dc_alt_pc,
    output logic [ROB_W-1:0]  rob_tail,
    output logic              rob_full,
    input  logic              rs_has_output,
    input  logic [ROB_W-1:0]  rs_rob_id,
    input  logic [31:0]       rs_output,
    input  logic              is_lsb,
    input  logic [ROB_W-1:0]  lsb_rob_id,
    input  logic [31:0]       lsb_res,
    input  logic [ROB_W-1:0]  q1_id,
    input  logic [ROB_W-1:0]  q2_id,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [31:0]       q1_val,
    output logic [31:0]       q2_val,
    output logic              commit_valid,
    output logic [4:0]        commit_rd,
    output logic [31:0]       commit_val,
    output logic [ROB_W-1:0]  commit_id,
    output logic              store_commit,
    output logic [ROB_W-1:0]  store_id,
    output logic              rob_clear,
    output logic [31:0]       clear_pc
);

    typedef enum logic [1:0] {
        OP_REG    = 2'd0,
        OP_STORE  = 2'd1,
        OP_BRANCH = 2'd2,
        OP_JALR   = 2'd3
    } op_type_t;

    localparam logic [ROB_W:0] SIZE_CNT = ROB_SIZE[ROB_W:0];

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] pred;
    op_type_t            ent_type [ROB_SIZE];
    logic [4:0]          ent_rd   [ROB_SIZE];
    logic [31:0]         alt_pc   [ROB_SIZE];
    logic [31:0]         value    [ROB_SIZE];

    logic [ROB_W-1:0] head;
    logic [ROB_W-1:0] tail;
    logic [ROB_W:0]   count;
    logic [ROB_W:0]   next_count;

    logic do_commit;
    logic mispredict;
    logic do_issue;

    assign rob_tail = tail;

    // Head retires once its result is in. A branch whose actual direction
    // disagrees with the prediction turns that retirement into a full flush.
    // Issue is dropped on overflow, during the flush edge, and while the
    // flush pulse is out (the decoder is still on the wrong path then).
    always_comb begin
        do_commit  = busy[head] && ready[head];
        mispredict = do_commit && (ent_type[head] == OP_BRANCH) &&
                     (value[head][0] != pred[head]);
        do_issue   = dc_valid && (count != SIZE_CNT) && !rob_clear && !mispredict;
    end

    // Occupancy bookkeeping; a flush empties the buffer regardless of
    // whatever issue/commit would otherwise have happened.
    always_comb begin
        next_count = count;
        if (do_issue && !do_commit) begin
            next_count = count + 1'b1;
        end else if (!do_issue && do_commit) begin
            next_count = count - 1'b1;
        end
        if (mispredict) begin
            next_count = '0;
        end
    end

    // Operand lookup: stored result first, then the ALU bus, then the LSB bus.
    // The bypass lets a consumer pick up a result in the cycle it is broadcast.
    always_comb begin
        q1_ready = 1'b0;
        q1_val   = '0;
        q2_ready = 1'b0;
        q2_val   = '0;
        if (busy[q1_id] && ready[q1_id]) begin
            q1_ready = 1'b1;
            q1_val   = value[q1_id];
        end else if (rs_has_output && (rs_rob_id == q1_id)) begin
            q1_ready = 1'b1;
            q1_val   = rs_output;
        end else if (is_lsb && (lsb_rob_id == q1_id)) begin
            q1_ready = 1'b1;
            q1_val   = lsb_res;
        end
        if (busy[q2_id] && ready[q2_id]) begin
            q2_ready = 1'b1;
            q2_val   = value[q2_id];
        end else if (rs_has_output && (rs_rob_id == q2_id)) begin
            q2_ready = 1'b1;
            q2_val   = rs_output;
        end else if (is_lsb && (lsb_rob_id == q2_id)) begin
            q2_ready = 1'b1;
            q2_val   = lsb_res;
        end
    end

    // Main state update. Statement order matters: the LSB write-back comes
    // after the ALU one so it wins on a same-id collision, and the flush
    // comes last so it overrides every other update in that cycle.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy         <= '0;
            ready        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rob_full     <= 1'b0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_val   <= '0;
            commit_id    <= '0;
            store_commit <= 1'b0;
            store_id     <= '0;
            rob_clear    <= 1'b0;
            clear_pc     <= '0;
        end else if (rdy_in) begin
            commit_valid <= 1'b0;
            store_commit <= 1'b0;
            rob_clear    <= 1'b0;

            if (rs_has_output && busy[rs_rob_id]) begin
                ready[rs_rob_id] <= 1'b1;
                value[rs_rob_id] <= rs_output;
            end
            if (is_lsb && busy[lsb_rob_id]) begin
                ready[lsb_rob_id] <= 1'b1;
                value[lsb_rob_id] <= lsb_res;
            end

            if (do_commit) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                head        <= head + 1'b1;
                case (ent_type[head])
                    OP_REG, OP_JALR: begin
                        commit_valid <= 1'b1;
                        commit_rd    <= ent_rd[head];
                        commit_val   <= value[head];
                        commit_id    <= head;
                    end
                    OP_STORE: begin
                        store_commit <= 1'b1;
                        store_id     <= head;
                    end
                    default: ;
                endcase
            end

            if (do_issue) begin
                busy[tail]     <= 1'b1;
                ready[tail]    <= (dc_type == OP_STORE);
                ent_type[tail] <= op_type_t'(dc_type);
                ent_rd[tail]   <= dc_rd;
                pred[tail]     <= dc_pred;
                alt_pc[tail]   <= dc_alt_pc;
                tail           <= tail + 1'b1;
            end

            count    <= next_count;
            rob_full <= (next_count >= SIZE_CNT - 1'b1);

            if (mispredict) begin
                busy      <= '0;
                ready     <= '0;
                head      <= '0;
                tail      <= '0;
                rob_clear <= 1'b1;
                clear_pc  <= alt_pc[head];
            end
        end
    end

endmodule
